weight_ram_loader: RTL and testbench
====================================

WEIGHT_RAM_LOADER -- requirements
Module: weight_ram_loader

Interface
REQ-001 SHALL have parameter KERNEL_SIZE, default 5, meaning kernel edge length.
REQ-002 SHALL have parameter KERNEL_WIDTH, default 2, meaning bits per ternary weight.
REQ-003 SHALL have parameter Tm, default 8, meaning kernels packed per weight RAM read row.
REQ-004 SHALL have parameter ADDR_W, default 10, meaning write-port address width (1024 words).
REQ-005 SHALL derive WORD_W = KERNEL_SIZE*KERNEL_SIZE*KERNEL_WIDTH (50), meaning one kernel per written word.
REQ-006 clk  input  1  clock; all logic on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  one-cycle request to begin a load.
REQ-009 abort  input  1  synchronous cancel of a load in progress.
REQ-010 base_addr  input  ADDR_W  first word address of the load.
REQ-011 num_words  input  ADDR_W+1  number of kernel words to load.
REQ-012 s_valid  input  1  upstream word valid.
REQ-013 s_data  input  WORD_W  upstream kernel word.
REQ-014 s_ready  output  1  loader accepts word this cycle.
REQ-015 ram_ena / ram_wea  output  1 / 1  weight RAM port-A enable / write enable.
REQ-016 ram_addra  output  ADDR_W  weight RAM port-A address.
REQ-017 ram_dina  output  WORD_W  weight RAM port-A data.
REQ-018 busy  output  1  load in progress (LOAD or DRAIN).
REQ-019 done  output  1  one-cycle pulse, load completed.
REQ-020 err  output  1  one-cycle pulse, start rejected.

Function
REQ-021 SHALL implement FSM states IDLE, LOAD, DRAIN, DONE.
REQ-022 IDLE + start + valid params SHALL latch base_addr/num_words and enter LOAD next cycle.
REQ-023 Params valid only if num_words != 0, num_words <= 2^ADDR_W, num_words[2:0]==0, base_addr[2:0]==0 (Tm-row aligned); otherwise err pulses next cycle and FSM stays IDLE.
REQ-024 s_ready SHALL be 1 only in LOAD; handshake = s_valid & s_ready.
REQ-025 Handshake at cycle t SHALL produce ram_ena=ram_wea=1, ram_dina=s_data, ram_addra=current address at cycle t+1 (registered, latency 1).
REQ-026 Write address SHALL start at base_addr, increment per handshake, wrap modulo 2^ADDR_W.
REQ-027 ram_ena/ram_wea SHALL be 0 in every cycle without a pending write; ram_addra/ram_dina hold last value.
REQ-028 Handshake of the final word SHALL move FSM to DRAIN; s_ready is 0 from the next cycle.
REQ-029 DRAIN SHALL last one cycle (final write issued), then DONE; done=1 during DONE only, then IDLE.
REQ-030 Last handshake at t: write at t+1, done at t+2, busy low at t+2.
REQ-031 s_valid low in LOAD SHALL stall without timeout; word counter and address unchanged.
REQ-032 start while busy or in DONE SHALL be ignored, no err.
REQ-033 abort in LOAD SHALL return FSM to IDLE next cycle without done; a write registered from the abort cycle's handshake is discarded (handshake suppressed: s_ready forced 0 when abort=1).
REQ-034 abort in IDLE/DRAIN/DONE SHALL be ignored.
REQ-035 Word counter SHALL be ADDR_W+1 bits so num_words=1024 terminates correctly.

Reset
REQ-036 On rst_n low: FSM=IDLE; s_ready, ram_ena, ram_wea, busy, done, err = 0; ram_addra, ram_dina, counters = 0.
REQ-037 Reset mid-load SHALL abandon the load immediately; no write or done follows deassertion.

Structure
REQ-038 KERNEL_SIZE, KERNEL_WIDTH, Tm, ADDR_W defaults and FSM state encodings SHALL live in the shared network_para header.
REQ-039 Single module, no sub-modules; RAM instance stays in the consumer-side controller.

Verification
REQ-040 base=0, num=8, s_valid always 1, data=k -> writes addr 0..7 data 0..7 on consecutive cycles, done 2 cycles after last handshake.
REQ-041 base=16, num=16, s_valid toggling 1/0 -> 16 writes at addr 16..31 in order, no gaps in address, single done.
REQ-042 base=1016, num=16 -> writes 1016..1023 then 0..7 (wrap), done once.
REQ-043 start with num=0, num=12, base=4, num=1032 -> err pulse each, busy stays 0, no writes.
REQ-044 abort after 3 handshakes of num=8 -> exactly 3 writes, no done, next start loads normally from new base.
REQ-045 rst_n low after 5 handshakes -> all outputs 0 immediately, no further writes; num=1024 load afterwards completes with 1024 writes.

Source files
------------

// File: rtl/weight_ram_loader_pkg.sv
// -----------------------------------------------------------------------------
// weight_ram_loader_pkg
// Shared network parameters for the weight-loading path: kernel geometry,
// weight RAM packing factor and write-port address width, plus the loader
// FSM state encoding. Imported by weight_ram_loader.
// -----------------------------------------------------------------------------
package weight_ram_loader_pkg;

    // Kernel edge length (kernels are KERNEL_SIZE x KERNEL_SIZE).
    localparam int KERNEL_SIZE_DEF  = 5;
    // Bits per ternary weight.
    localparam int KERNEL_WIDTH_DEF = 2;
    // Kernels packed into one weight RAM read row; loads must be row aligned.
    localparam int TM_DEF           = 8;
    // Write-port address width (1024 words).
    localparam int ADDR_W_DEF       = 10;

    // Loader FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

endpackage : weight_ram_loader_pkg

// File: rtl/weight_ram_loader.sv
// -----------------------------------------------------------------------------
// weight_ram_loader
// Streams kernel words from an upstream valid/ready source into port A of the
// weight RAM, starting at base_addr and writing num_words consecutive words
// (address wraps modulo 2^ADDR_W). One kernel per written word.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 one-cycle request to begin a load
//   abort                 synchronous cancel of a load in progress
//   base_addr [ADDR_W]    first word address (must be Tm aligned)
//   num_words [ADDR_W+1]  word count, 1..2^ADDR_W, multiple of Tm
//   s_valid / s_data      upstream word valid / kernel word
//   s_ready               loader accepts a word this cycle
//   ram_ena / ram_wea     weight RAM port-A enable / write enable
//   ram_addra / ram_dina  weight RAM port-A address / data
//   busy                  load in progress (LOAD or DRAIN)
//   done                  one-cycle pulse, load completed
//   err                   one-cycle pulse, start rejected (bad parameters)
// -----------------------------------------------------------------------------
module weight_ram_loader
    import weight_ram_loader_pkg::*;
#(
    parameter  int KERNEL_SIZE  = KERNEL_SIZE_DEF,
    parameter  int KERNEL_WIDTH = KERNEL_WIDTH_DEF,
    parameter  int Tm           = TM_DEF,
    parameter  int ADDR_W       = ADDR_W_DEF,
    localparam int WORD_W       = KERNEL_SIZE * KERNEL_SIZE * KERNEL_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    input  logic              s_valid,
    input  logic [WORD_W-1:0] s_data,
    output logic              s_ready,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [WORD_W-1:0] ram_dina,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Largest legal load: the whole RAM. The counter is one bit wider than the
    // address so this value is representable.
    localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   TM_WORDS  = (ADDR_W + 1)'(Tm);
    localparam logic [ADDR_W-1:0] TM_ADDR   = ADDR_W'(Tm);

    loader_state_t     state_q;
    logic [ADDR_W-1:0] addr_q;   // next write address
    logic [ADDR_W:0]   num_q;    // latched word count
    logic [ADDR_W:0]   cnt_q;    // words accepted so far

    logic params_ok;
    logic hs;
    logic last_word;

    always_comb begin
        params_ok = (num_words != '0)
                 && (num_words <= MAX_WORDS)
                 && ((num_words % TM_WORDS) == '0)
                 && ((base_addr % TM_ADDR) == '0);
    end

    // abort masks s_ready so the abort cycle can never complete a handshake;
    // that is what keeps a half-accepted word out of the RAM.
    assign s_ready   = (state_q == ST_LOAD) && !abort;
    assign hs        = s_valid && s_ready;
    assign last_word = ((cnt_q + 1'b1) == num_q);

    // Status decodes straight from the state register, so they are glitch-free.
    assign busy = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign done = (state_q == ST_DONE);

    // NOTE: every register here, datapath included, sits on the async reset so
    // a reset mid-load leaves nothing behind; all state updates use <= so every
    // branch sees the pre-edge values of state_q, cnt_q and addr_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            num_q     <= '0;
            cnt_q     <= '0;
            ram_ena   <= 1'b0;
            ram_wea   <= 1'b0;
            ram_addra <= '0;
            ram_dina  <= '0;
            err       <= 1'b0;
        end else begin
            // Write port is a one-cycle registered copy of the handshake;
            // address and data hold their last value when no write is pending.
            ram_ena <= hs;
            ram_wea <= hs;
            err     <= 1'b0;
            if (hs) begin
                ram_addra <= addr_q;
                ram_dina  <= s_data;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (params_ok) begin
                            addr_q  <= base_addr;
                            num_q   <= num_words;
                            cnt_q   <= '0;
                            state_q <= ST_LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else if (hs) begin
                        addr_q <= addr_q + 1'b1;   // wraps modulo 2^ADDR_W
                        cnt_q  <= cnt_q + 1'b1;
                        if (last_word) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end

                // The final write is on the port during DRAIN.
                ST_DRAIN: state_q <= ST_DONE;

                ST_DONE:  state_q <= ST_IDLE;

                default:  state_q <= ST_IDLE;
            endcase
        end
    end

endmodule : weight_ram_loader

// File: tb/tb_weight_ram_loader.sv
// -----------------------------------------------------------------------------
// tb_weight_ram_loader
// Self-checking bench for weight_ram_loader. The reference model is a list of
// expected writes built from the accepted words: the k-th accepted word of a
// load must appear at address (base + k) mod 1024 one cycle after its
// handshake, and done must pulse two cycles after the last handshake.
// -----------------------------------------------------------------------------
module tb_weight_ram_loader;

    localparam int AW    = 10;
    localparam int WW    = 50;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic          s_valid;
    logic [WW-1:0] s_data;
    logic          s_ready;
    logic          ram_ena;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [WW-1:0] ram_dina;
    logic          busy;
    logic          done;
    logic          err;

    weight_ram_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .num_words (num_words),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    typedef struct {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
        int            c;
    } wr_t;

    wr_t act_wr[$];
    int  done_cyc[$];
    int  err_cyc[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_ena || ram_wea) begin
                check("wea_matches_ena", 64'(ram_wea), 64'(ram_ena));
                act_wr.push_back(wr_t'{ram_addra, ram_dina, cyc});
            end
            if (done) begin
                done_cyc.push_back(cyc);
                check("busy_low_at_done", 64'(busy), 64'(0));
            end
            if (err) begin
                err_cyc.push_back(cyc);
                check("busy_low_at_err", 64'(busy), 64'(0));
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic check_all_zero(input string tag);
        check({tag, " s_ready"},   64'(s_ready),   64'(0));
        check({tag, " ram_ena"},   64'(ram_ena),   64'(0));
        check({tag, " ram_wea"},   64'(ram_wea),   64'(0));
        check({tag, " busy"},      64'(busy),      64'(0));
        check({tag, " done"},      64'(done),      64'(0));
        check({tag, " err"},       64'(err),       64'(0));
        check({tag, " ram_addra"}, 64'(ram_addra), 64'(0));
        check({tag, " ram_dina"},  64'(ram_dina),  64'(0));
    endtask

    // Called #1 after a rising edge; returns the cycle in which start is seen.
    task automatic issue_start(input int base, input int num, output int sc);
        base_addr = AW'(base);
        num_words = (AW + 1)'(num);
        start     = 1'b1;
        sc        = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // mode: 0 = s_valid always 1, data = k; 1 = s_valid toggling;
    //       2 = random s_valid/data plus stray start pulses with junk params.
    // abort_at / rst_at: word index at which to abort / reset (-1 = never).
    task automatic do_load(input string tag, input int base, input int num,
                           input int mode, input int abort_at, input int rst_at);
        wr_t exp_wr[$];
        int  k       = 0;
        int  last_hs = -1;
        int  budget;
        int  sc;
        bit  cut     = 1'b0;
        bit  ab;
        int  n;

        act_wr.delete();
        done_cyc.delete();
        err_cyc.delete();
        s_valid = 1'b0;
        issue_start(base, num, sc);
        budget = 4 * num + 20;

        while (k < num && budget > 0 && !cut) begin
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = ~s_valid;
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            s_data = (mode == 0) ? WW'(k) : {18'($urandom), $urandom};
            if (mode == 2) begin
                start     = ($urandom_range(0, 5) == 0);
                base_addr = AW'($urandom);
                num_words = (AW + 1)'($urandom);
            end
            ab = (abort_at == k);
            if (ab) begin
                abort   = 1'b1;
                s_valid = 1'b1;
            end

            if (rst_at == k) begin
                s_valid = 1'b0;
                @(negedge clk);          // let the previous write be observed
                #1;
                rst_n = 1'b0;
                #1;
                check_all_zero({tag, " reset_mid_load"});
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
                cut   = 1'b1;
            end else begin
                @(negedge clk);
                if (ab) check({tag, " s_ready_during_abort"}, 64'(s_ready), 64'(0));
                if (s_valid && s_ready) begin
                    exp_wr.push_back(wr_t'{AW'((base + k) % DEPTH), s_data, cyc + 1});
                    last_hs = cyc;
                    k++;
                end
                @(posedge clk);
                #1;
                if (ab) begin
                    abort = 1'b0;
                    cut   = 1'b1;
                end
            end
            budget--;
        end

        start   = 1'b0;
        s_valid = 1'b0;
        abort   = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        if (!cut) check({tag, " words_accepted"}, 64'(k), 64'(num));
        check({tag, " write_count"}, 64'(act_wr.size()), 64'(exp_wr.size()));
        n = (act_wr.size() < exp_wr.size()) ? act_wr.size() : exp_wr.size();
        for (int i = 0; i < n; i++) begin
            check({tag, " wr_addr"},  64'(act_wr[i].addr), 64'(exp_wr[i].addr));
            check({tag, " wr_data"},  64'(act_wr[i].data), 64'(exp_wr[i].data));
            check({tag, " wr_cycle"}, 64'(act_wr[i].c),    64'(exp_wr[i].c));
        end
        check({tag, " err_count"}, 64'(err_cyc.size()), 64'(0));
        if (!cut && k == num) begin
            check({tag, " done_count"}, 64'(done_cyc.size()), 64'(1));
            if (done_cyc.size() == 1)
                check({tag, " done_cycle"}, 64'(done_cyc[0]), 64'(last_hs + 2));
        end else begin
            check({tag, " no_done"}, 64'(done_cyc.size()), 64'(0));
        end
        check({tag, " idle_after"}, 64'(busy), 64'(0));
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        int base;
        int num;
        bit exp_err;
    } err_vec_t;

    err_vec_t ev[6];

    initial begin
        int sc;

        ev[0] = '{0,    0,    1'b1};   // zero words
        ev[1] = '{0,    12,   1'b1};   // count not a row multiple
        ev[2] = '{4,    8,    1'b1};   // base not row aligned
        ev[3] = '{0,    1032, 1'b1};   // larger than the RAM
        ev[4] = '{8,    4,    1'b1};   // partial row
        ev[5] = '{1020, 2048, 1'b1};   // misaligned and oversized

        rst_n     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = '0;
        num_words = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Rejected starts: err pulse next cycle, no load.
        for (int i = 0; i < 6; i++) begin
            err_cyc.delete();
            act_wr.delete();
            issue_start(ev[i].base, ev[i].num, sc);
            check("bad_param busy", 64'(busy), 64'(0));
            repeat (3) @(posedge clk);
            #1;
            check("bad_param err_count", 64'(err_cyc.size()), 64'(ev[i].exp_err));
            if (err_cyc.size() > 0) check("bad_param err_cycle", 64'(err_cyc[0]), 64'(sc + 1));
            check("bad_param no_writes", 64'(act_wr.size()), 64'(0));
            check("bad_param busy_after", 64'(busy), 64'(0));
        end

        do_load("basic",   0,    8,    0, -1, -1);
        do_load("toggle",  16,   16,   1, -1, -1);
        do_load("wrap",    1016, 16,   0, -1, -1);
        do_load("abort",   40,   8,    0,  3, -1);
        do_load("after_abort", 64, 8,  2, -1, -1);
        do_load("reset",   128,  16,   0, -1,  5);
        do_load("full",    0,    1024, 0, -1, -1);

        for (int r = 0; r < 5; r++) begin
            int b = 8 * int'($urandom_range(0, DEPTH / 8 - 1));
            int n = 8 * int'($urandom_range(1, 8));
            do_load("random", b, n, 2, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_weight_ram_loader
